// File: rtl/mem_sram_bus_adapter.sv
// Adapter from the core's req/gnt + recv/ack memory bus onto a single-port SRAM model.
// One transaction in flight; the SRAM's registered read port doubles as the response data buffer.
module mem_sram_bus_adapter #(
    parameter int unsigned       WIDTH  = 64,
    parameter int unsigned       DEPTH  = 1024,
    parameter int unsigned       ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter bit                ROM    = 1'b0
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     mem_req,
    output logic                     mem_gnt,
    input  logic                     mem_wen,
    input  logic [WIDTH/8-1:0]       mem_strb,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [WIDTH-1:0]         mem_wdata,
    output logic                     mem_recv,
    input  logic                     mem_ack,
    output logic                     mem_error,
    output logic [WIDTH-1:0]         mem_rdata,
    output logic                     sram_cen,
    output logic [WIDTH/8-1:0]       sram_wstrb,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [WIDTH-1:0]         sram_wdata,
    input  logic [WIDTH-1:0]         sram_rdata,
    input  logic                     sram_err
);

    localparam int LSB = $clog2(WIDTH / 8);
    localparam int HI  = LSB + $clog2(DEPTH);

    logic in_range;
    logic rom_write;
    logic accept;
    logic resp_done;

    logic p_valid;
    logic p_err;
    logic p_wen;

    // Byte offset inside a word is carried by the strobes, not the address.
    if (LSB > 0) begin : g_offset
        logic unused_offset;
        assign unused_offset = ^mem_addr[LSB-1:0];
    end

    // Request side: decode, grant and SRAM drive
    assign in_range  = (mem_addr[ADDR_W-1:HI] == BASE[ADDR_W-1:HI]);
    assign rom_write = ROM && mem_wen;

    assign mem_gnt   = g_resetn && (!p_valid || mem_ack);
    assign accept    = mem_req && mem_gnt;
    assign resp_done = p_valid && mem_ack;

    assign sram_cen   = accept && in_range && !rom_write;
    assign sram_wstrb = (sram_cen && mem_wen) ? mem_strb : '0;
    assign sram_addr  = mem_addr[HI-1:LSB];
    assign sram_wdata = mem_wdata;

    // Pipe register P: a new accept takes priority over retiring the old response
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            p_valid <= 1'b0;
            p_err   <= 1'b0;
            p_wen   <= 1'b0;
        end else if (accept) begin
            p_valid <= 1'b1;
            p_err   <= !in_range || rom_write;
            p_wen   <= mem_wen;
        end else if (resp_done) begin
            p_valid <= 1'b0;
        end
    end

    // Response side: sram_rdata stays put while stalled because cen is held low
    assign mem_recv  = g_resetn && p_valid;
    assign mem_error = g_resetn && p_valid && (p_err || (ROM && sram_err));
    assign mem_rdata = (g_resetn && p_valid && !p_wen && !p_err) ? sram_rdata : '0;

endmodule
